// File: rtl/v7_peak_reader_pkg.sv
// Shared types and default parameters for the v7 peak reader.
package v7_peak_reader_pkg;

    // Default configuration matching the v7 shaping filter output.
    localparam int unsigned DEF_DW      = 36;
    localparam int unsigned DEF_TS_W    = 32;
    localparam int unsigned DEF_WID_W   = 12;
    localparam int          DEF_THR_HI  = 1000;
    localparam int          DEF_THR_LO  = 500;
    localparam int unsigned DEF_MAX_WID = 1024;
    localparam int unsigned DEF_DEAD_T  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StDead
    } v7_pr_state_t;

    // Event record at the default widths; the top builds the same layout from its parameters.
    typedef struct packed {
        logic signed [DEF_DW-1:0] amp;
        logic [DEF_WID_W-1:0]     width;
        logic [DEF_TS_W-1:0]      ts;
        logic                     pileup;
    } ev_rec_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/v7_peak_reader_if.sv
// Event record handshake between the peak reader and the readout logic.
interface v7_peak_reader_if
    import v7_peak_reader_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned TS_W  = DEF_TS_W,
    parameter int unsigned WID_W = DEF_WID_W
) ();

    logic                 ev_valid;
    logic                 ev_ready;
    logic signed [DW-1:0] ev_amp;
    logic [WID_W-1:0]     ev_width;
    logic [TS_W-1:0]      ev_ts;
    logic                 ev_pileup;

    modport master (
        output ev_valid,
        output ev_amp,
        output ev_width,
        output ev_ts,
        output ev_pileup,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_amp,
        input  ev_width,
        input  ev_ts,
        input  ev_pileup,
        output ev_ready
    );

endinterface

// File: rtl/v7_peak_reader_event_slot.sv
// Single-entry valid/ready output register with load/release/drop decision and drop counter.
module v7_peak_reader_event_slot #(
    parameter int unsigned REC_W = 81
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_emit,
    input  logic [REC_W-1:0] i_rec,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [REC_W-1:0] o_rec,
    output logic [15:0]      o_drop_cnt
);

    logic             r_valid;
    logic [REC_W-1:0] r_rec;
    logic [15:0]      r_drop_cnt;

    logic w_release;
    logic w_load;
    logic w_drop;
    logic w_valid_nxt;

    // Decide whether an emitted record is loaded or dropped; a same-cycle release frees the slot.
    always_comb begin
        w_release   = r_valid & i_ready;
        w_load      = i_emit & (~r_valid | w_release);
        w_drop      = i_emit & r_valid & ~i_ready;
        w_valid_nxt = w_load | (r_valid & ~w_release);
    end

    // Slot register and saturating drop counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid    <= 1'b0;
            r_rec      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_load) begin
                r_rec <= i_rec;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_rec      = r_rec;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/v7_peak_reader.sv
// Pulse detector for the v7 trapezoid stream: hysteresis arm/release, peak, width and timestamp.
module v7_peak_reader
    import v7_peak_reader_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned TS_W    = DEF_TS_W,
    parameter int unsigned WID_W   = DEF_WID_W,
    parameter int          THR_HI  = DEF_THR_HI,
    parameter int          THR_LO  = DEF_THR_LO,
    parameter int unsigned MAX_WID = DEF_MAX_WID,
    parameter int unsigned DEAD_T  = DEF_DEAD_T
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic signed [DW-1:0] i_data_in,
    v7_peak_reader_if.master     ev_if,
    output logic [15:0]          o_drop_cnt,
    output logic                 o_busy
);

    // Thresholds sign-extended so every compare is a signed DW-bit compare.
    localparam logic signed [DW-1:0] THR_HI_S = DW'(THR_HI);
    localparam logic signed [DW-1:0] THR_LO_S = DW'(THR_LO);

    // The internal width counter is wide enough to reach MAX_WID even when WID_W is narrower,
    // so pile-up is still detected after the reported width has saturated.
    localparam int unsigned    CW        = max_u(WID_W, $clog2(MAX_WID + 1));
    localparam logic [CW-1:0]  CNT_MAX   = '1;
    localparam logic [CW-1:0]  WID_ONES  = CW'({WID_W{1'b1}});
    localparam logic [CW-1:0]  MAX_WID_C = CW'(MAX_WID);

    localparam int unsigned    DCW       = (DEAD_T > 1) ? $clog2(DEAD_T) : 1;
    localparam logic [DCW-1:0] DEAD_LAST = (DEAD_T == 0) ? '0 : DCW'(DEAD_T - 1);

    typedef struct packed {
        logic signed [DW-1:0] amp;
        logic [WID_W-1:0]     width;
        logic [TS_W-1:0]      ts;
        logic                 pileup;
    } rec_t;

    localparam int unsigned REC_W = $bits(rec_t);

    v7_pr_state_t         r_state;
    logic [TS_W-1:0]      r_ts;
    logic signed [DW-1:0] r_max;
    logic [CW-1:0]        r_width;
    logic [TS_W-1:0]      r_ts_cap;
    logic [DCW-1:0]       r_dead_cnt;

    v7_pr_state_t         w_state_nxt;
    logic signed [DW-1:0] w_max_nxt;
    logic [CW-1:0]        w_width_nxt;
    logic [TS_W-1:0]      w_ts_cap_nxt;
    logic [DCW-1:0]       w_dead_nxt;
    logic                 w_emit;
    logic                 w_above_hi;
    logic                 w_above_lo;
    rec_t                 w_rec;
    rec_t                 w_slot_rec;
    logic                 w_slot_valid;

    assign w_above_hi = i_data_in > THR_HI_S;
    assign w_above_lo = i_data_in > THR_LO_S;

    // Next-state logic: arm on THR_HI, track peak and width until THR_LO, then optional dead time.
    always_comb begin
        w_state_nxt  = r_state;
        w_max_nxt    = r_max;
        w_width_nxt  = r_width;
        w_ts_cap_nxt = r_ts_cap;
        w_dead_nxt   = r_dead_cnt;
        w_emit       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_above_hi) begin
                    w_state_nxt  = StTrack;
                    w_max_nxt    = i_data_in;
                    w_width_nxt  = CW'(1);
                    w_ts_cap_nxt = r_ts;
                end
            end
            StTrack: begin
                if (w_above_lo) begin
                    if (r_width != CNT_MAX) begin
                        w_width_nxt = r_width + CW'(1);
                    end
                    if (i_data_in > r_max) begin
                        w_max_nxt = i_data_in;
                    end
                end else begin
                    // Ending sample is not part of the pulse; record uses the current width.
                    w_emit      = 1'b1;
                    w_dead_nxt  = '0;
                    w_state_nxt = (DEAD_T == 0) ? StIdle : StDead;
                end
            end
            StDead: begin
                if (r_dead_cnt == DEAD_LAST) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_dead_nxt = r_dead_cnt + DCW'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Record presented to the slot when the pulse ends.
    always_comb begin
        w_rec.amp    = r_max;
        w_rec.width  = (r_width > WID_ONES) ? WID_ONES[WID_W-1:0] : r_width[WID_W-1:0];
        w_rec.ts     = r_ts_cap;
        w_rec.pileup = (r_width >= MAX_WID_C);
    end

    // FSM, tracking registers and free-running timestamp.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_ts       <= '0;
            r_max      <= '0;
            r_width    <= '0;
            r_ts_cap   <= '0;
            r_dead_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ts       <= r_ts + TS_W'(1);
            r_max      <= w_max_nxt;
            r_width    <= w_width_nxt;
            r_ts_cap   <= w_ts_cap_nxt;
            r_dead_cnt <= w_dead_nxt;
        end
    end

    v7_peak_reader_event_slot #(
        .REC_W (REC_W)
    ) u_event_slot (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_emit     (w_emit),
        .i_rec      (w_rec),
        .i_ready    (ev_if.ev_ready),
        .o_valid    (w_slot_valid),
        .o_rec      (w_slot_rec),
        .o_drop_cnt (o_drop_cnt)
    );

    assign ev_if.ev_valid  = w_slot_valid;
    assign ev_if.ev_amp    = w_slot_rec.amp;
    assign ev_if.ev_width  = w_slot_rec.width;
    assign ev_if.ev_ts     = w_slot_rec.ts;
    assign ev_if.ev_pileup = w_slot_rec.pileup;
    assign o_busy          = (r_state != StIdle);

endmodule

// File: tb/tb_v7_peak_reader.sv
// Self-checking bench for v7_peak_reader: directed scenarios plus randomized stream vs. model.
module tb_v7_peak_reader;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [35:0] data;
    logic               rdy;

    logic [15:0] drop0, drop1, drop2;
    logic        busy0, busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // 0: defaults; 1: MAX_WID=16; 2: MAX_WID=16, WID_W=4, DEAD_T=0.
    v7_peak_reader_if #(.DW(36), .TS_W(32), .WID_W(12)) if0 ();
    v7_peak_reader_if #(.DW(36), .TS_W(32), .WID_W(12)) if1 ();
    v7_peak_reader_if #(.DW(36), .TS_W(32), .WID_W(4))  if2 ();

    assign if0.ev_ready = rdy;
    assign if1.ev_ready = rdy;
    assign if2.ev_ready = rdy;

    v7_peak_reader u0 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_data_in  (data),
        .ev_if      (if0),
        .o_drop_cnt (drop0),
        .o_busy     (busy0)
    );

    v7_peak_reader #(.MAX_WID(16)) u1 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_data_in  (data),
        .ev_if      (if1),
        .o_drop_cnt (drop1),
        .o_busy     (busy1)
    );

    v7_peak_reader #(.WID_W(4), .MAX_WID(16), .DEAD_T(0)) u2 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_data_in  (data),
        .ev_if      (if2),
        .o_drop_cnt (drop2),
        .o_busy     (busy2)
    );

    // Behavioural reference: pulse bookkeeping per configuration, one output slot each.
    int     cfg_dead [3] = '{4, 4, 0};
    int     cfg_max  [3] = '{1024, 16, 16};
    int     cfg_wid  [3] = '{12, 12, 4};
    longint m_ts = 0;
    bit     m_pulse  [3];
    int     m_dead   [3];
    longint m_max    [3];
    int     m_cnt    [3];
    longint m_start  [3];
    bit     m_valid  [3];
    longint m_amp    [3];
    int     m_wid    [3];
    longint m_ts_o   [3];
    bit     m_pile   [3];
    int     m_drop   [3];

    function automatic void model_edge(input longint d, input bit r, input bit rst);
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                m_pulse[c] = 0; m_dead[c] = 0; m_max[c] = 0; m_cnt[c] = 0; m_start[c] = 0;
                m_valid[c] = 0; m_amp[c] = 0; m_wid[c] = 0; m_ts_o[c] = 0; m_pile[c] = 0;
                m_drop[c] = 0;
            end else begin
                bit     emit = 0;
                bit     rel  = m_valid[c] && r;
                int     lim  = (1 << cfg_wid[c]) - 1;
                if (m_pulse[c]) begin
                    if (d > 500) begin
                        m_cnt[c]++;
                        if (d > m_max[c]) m_max[c] = d;
                    end else begin
                        emit       = 1;
                        m_pulse[c] = 0;
                        m_dead[c]  = cfg_dead[c];
                    end
                end else if (m_dead[c] > 0) begin
                    m_dead[c]--;
                end else if (d > 1000) begin
                    m_pulse[c] = 1;
                    m_max[c]   = d;
                    m_cnt[c]   = 1;
                    m_start[c] = m_ts;
                end
                if (emit) begin
                    if (!m_valid[c] || rel) begin
                        m_valid[c] = 1;
                        m_amp[c]   = m_max[c];
                        m_wid[c]   = (m_cnt[c] > lim) ? lim : m_cnt[c];
                        m_ts_o[c]  = m_start[c];
                        m_pile[c]  = (m_cnt[c] >= cfg_max[c]);
                    end else if (m_drop[c] < 65535) begin
                        m_drop[c]++;
                    end
                end else if (rel) begin
                    m_valid[c] = 0;
                end
            end
        end
        m_ts = rst ? 0 : ((m_ts + 1) & 64'hFFFF_FFFF);
    endfunction

    function automatic logic [98:0] obs(input int c);
        logic v, p, b;
        logic [35:0] a;
        logic [11:0] w;
        logic [31:0] t;
        logic [15:0] dc;
        case (c)
            0: begin
                v = if0.ev_valid; a = if0.ev_amp; w = if0.ev_width; t = if0.ev_ts;
                p = if0.ev_pileup; dc = drop0; b = busy0;
            end
            1: begin
                v = if1.ev_valid; a = if1.ev_amp; w = if1.ev_width; t = if1.ev_ts;
                p = if1.ev_pileup; dc = drop1; b = busy1;
            end
            default: begin
                v = if2.ev_valid; a = if2.ev_amp; w = {8'd0, if2.ev_width}; t = if2.ev_ts;
                p = if2.ev_pileup; dc = drop2; b = busy2;
            end
        endcase
        if (v !== 1'b1) begin
            a = '0; w = '0; t = '0; p = 1'b0;
        end
        return {v, a, w, t, p, dc, b};
    endfunction

    function automatic logic [98:0] expect_of(input int c);
        logic [35:0] a = m_amp[c][35:0];
        logic [11:0] w = 12'(m_wid[c]);
        logic [31:0] t = m_ts_o[c][31:0];
        logic        p = m_pile[c];
        if (!m_valid[c]) begin
            a = '0; w = '0; t = '0; p = 1'b0;
        end
        return {m_valid[c], a, w, t, p, 16'(m_drop[c]), (m_pulse[c] || m_dead[c] > 0)};
    endfunction

    // One clock: drive on the falling edge, advance the model at the rising edge, settle 1 ns.
    task automatic step(input longint d, input bit r, input bit rst);
        @(negedge clk);
        data  = d[35:0];
        rdy   = r;
        reset = rst;
        @(posedge clk);
        model_edge(d, r, rst);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(0, r, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(5000, 0, 1);
        n_checks++;
        if (if0.ev_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", if0.ev_valid);
        end
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy0);
        end
        n_checks++;
        if (drop0 !== 16'd0) begin
            n_fail++; $display("FAIL reset_drop: got %0d want 0", drop0);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0);
            n_checks++;
            if (if0.ev_valid !== 1'b0 || busy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_quiet: valid=%b busy=%b want 0/0", if0.ev_valid, busy0);
            end
        end
    endtask

    task automatic test_trapezoid();
        longint seq[$];
        bit     armed = 0;
        int     end_idx = -1;
        int     exp_w = 0;
        longint exp_ts = 0;
        for (int v = 0; v <= 3000; v += 300) seq.push_back(v);
        repeat (20) seq.push_back(3000);
        for (int v = 2700; v >= 0; v -= 300) seq.push_back(v);
        seq.push_back(0);
        for (int i = 0; i < seq.size(); i++) begin
            if (!armed && seq[i] > 1000) begin
                armed = 1; exp_ts = m_ts; exp_w = 1;
            end else if (armed && end_idx < 0) begin
                if (seq[i] > 500) exp_w++;
                else end_idx = i;
            end
            step(seq[i], 1, 0);
            if (end_idx < 0 || i == end_idx + 1) begin
                n_checks++;
                if (if0.ev_valid !== 1'b0) begin
                    n_fail++; $display("FAIL trap_valid_low[%0d]: got %b want 0", i, if0.ev_valid);
                end
            end else if (i == end_idx) begin
                n_checks++;
                if (if0.ev_valid !== 1'b1 || if0.ev_amp !== 36'sd3000 || if0.ev_width !== 12'd35 ||
                    if0.ev_width !== 12'(exp_w) || if0.ev_ts !== exp_ts[31:0] ||
                    if0.ev_pileup !== 1'b0) begin
                    n_fail++;
                    $display("FAIL trap_event: got v=%b amp=%0d w=%0d ts=%0d p=%b want 1/3000/%0d/%0d/0",
                             if0.ev_valid, if0.ev_amp, if0.ev_width, if0.ev_ts, if0.ev_pileup,
                             exp_w, exp_ts);
                end
                n_checks++;
                if (if1.ev_valid !== 1'b1 || if1.ev_width !== 12'd35 || if1.ev_pileup !== 1'b1) begin
                    n_fail++;
                    $display("FAIL trap_pileup16: got v=%b w=%0d p=%b want 1/35/1",
                             if1.ev_valid, if1.ev_width, if1.ev_pileup);
                end
            end
        end
        idle(6, 1);
    endtask

    task automatic test_hysteresis();
        longint seq[5] = '{1200, 800, 1100, 900, 400};
        for (int i = 0; i < 5; i++) step(seq[i], 1, 0);
        n_checks++;
        if (if0.ev_valid !== 1'b1 || if0.ev_width !== 12'd4 || if0.ev_amp !== 36'sd1200) begin
            n_fail++;
            $display("FAIL hyst_event: got v=%b w=%0d amp=%0d want 1/4/1200",
                     if0.ev_valid, if0.ev_width, if0.ev_amp);
        end
        idle(6, 1);
        step(600, 1, 0);
        step(-5000, 1, 0);
        step(600, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            n_checks++;
            if (if0.ev_valid !== 1'b0 || busy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL hyst_no_arm: valid=%b busy=%b want 0/0", if0.ev_valid, busy0);
            end
        end
    endtask

    task automatic test_backpressure();
        step(2000, 0, 0); step(2000, 0, 0); step(2000, 0, 0); step(0, 0, 0);
        idle(6, 0);
        n_checks++;
        if (if0.ev_valid !== 1'b1 || if0.ev_amp !== 36'sd2000 || if0.ev_width !== 12'd3) begin
            n_fail++;
            $display("FAIL bp_first: got v=%b amp=%0d w=%0d want 1/2000/3",
                     if0.ev_valid, if0.ev_amp, if0.ev_width);
        end
        step(3000, 0, 0); step(0, 0, 0);
        idle(6, 0);
        n_checks++;
        if (if0.ev_valid !== 1'b1 || if0.ev_amp !== 36'sd2000 || if0.ev_width !== 12'd3 ||
            drop0 !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_hold_drop: got v=%b amp=%0d w=%0d drop=%0d want 1/2000/3/1",
                     if0.ev_valid, if0.ev_amp, if0.ev_width, drop0);
        end
        step(2500, 0, 0); step(2500, 0, 0); step(0, 1, 0);
        n_checks++;
        if (if0.ev_valid !== 1'b1 || if0.ev_amp !== 36'sd2500 || if0.ev_width !== 12'd2 ||
            drop0 !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_third: got v=%b amp=%0d w=%0d drop=%0d want 1/2500/2/1",
                     if0.ev_valid, if0.ev_amp, if0.ev_width, drop0);
        end
        step(0, 1, 0);
        n_checks++;
        if (if0.ev_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got %b want 0", if0.ev_valid);
        end
        idle(6, 1);
    endtask

    task automatic test_pileup();
        for (int i = 0; i < 40; i++) step(2000, 1, 0);
        step(0, 1, 0);
        n_checks++;
        if (if1.ev_valid !== 1'b1 || if1.ev_width !== 12'd40 || if1.ev_pileup !== 1'b1) begin
            n_fail++;
            $display("FAIL pile_w12: got v=%b w=%0d p=%b want 1/40/1",
                     if1.ev_valid, if1.ev_width, if1.ev_pileup);
        end
        n_checks++;
        if (if2.ev_valid !== 1'b1 || if2.ev_width !== 4'd15 || if2.ev_pileup !== 1'b1) begin
            n_fail++;
            $display("FAIL pile_w4: got v=%b w=%0d p=%b want 1/15/1",
                     if2.ev_valid, if2.ev_width, if2.ev_pileup);
        end
        n_checks++;
        if (if0.ev_valid !== 1'b1 || if0.ev_width !== 12'd40 || if0.ev_pileup !== 1'b0) begin
            n_fail++;
            $display("FAIL pile_default: got v=%b w=%0d p=%b want 1/40/0",
                     if0.ev_valid, if0.ev_width, if0.ev_pileup);
        end
        idle(6, 1);
    endtask

    task automatic test_dead_time();
        step(2000, 1, 0); step(2000, 1, 0); step(2000, 1, 0); step(0, 1, 0);
        step(0, 1, 0);
        step(1500, 1, 0);
        step(1500, 1, 0);
        n_checks++;
        if (if0.ev_valid !== 1'b0 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL dead_ignore: valid=%b busy=%b want 0/1", if0.ev_valid, busy0);
        end
        step(0, 1, 0);
        n_checks++;
        if (if0.ev_valid !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL dead_expire: valid=%b busy=%b want 0/0", if0.ev_valid, busy0);
        end
        n_checks++;
        if (if2.ev_valid !== 1'b1 || if2.ev_width !== 4'd2 || if2.ev_amp !== 36'sd1500) begin
            n_fail++;
            $display("FAIL dead_zero_rearm: got v=%b w=%0d amp=%0d want 1/2/1500",
                     if2.ev_valid, if2.ev_width, if2.ev_amp);
        end
        idle(3, 1);
        // Pending event plus an active pulse, then reset.
        step(2000, 0, 0); step(2000, 0, 0); step(0, 0, 0);
        idle(6, 0);
        step(2000, 0, 0); step(2000, 0, 0);
        n_checks++;
        if (if0.ev_valid !== 1'b1 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_setup: valid=%b busy=%b want 1/1", if0.ev_valid, busy0);
        end
        step(2000, 0, 1);
        n_checks++;
        if (if0.ev_valid !== 1'b0 || busy0 !== 1'b0 || drop0 !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset: valid=%b busy=%b drop=%0d want 0/0/0",
                     if0.ev_valid, busy0, drop0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            n_checks++;
            if (if0.ev_valid !== 1'b0 || busy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_after: valid=%b busy=%b want 0/0", if0.ev_valid, busy0);
            end
        end
    endtask

    task automatic test_random();
        int     seg_left = 0;
        longint level = 0;
        for (int n = 0; n < 4000; n++) begin
            bit r;
            bit rst;
            longint d;
            if (seg_left == 0) begin
                seg_left = int'($urandom_range(1, 30));
                case ($urandom_range(0, 4))
                    0:       level = -longint'($urandom_range(0, 40000000));
                    1:       level = longint'($urandom_range(0, 1000));
                    default: level = longint'($urandom_range(0, 8000)) - 2000;
                endcase
            end
            seg_left--;
            d   = level + longint'($urandom_range(0, 400)) - 200;
            r   = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 799) == 0);
            step(d, r, rst);
            for (int c = 0; c < 3; c++) begin
                logic [98:0] got = obs(c);
                logic [98:0] exp = expect_of(c);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random[%0d] dut%0d: got %h want %h", n, c, got, exp);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        data  = '0;
        rdy   = 1'b0;
        test_reset();
        test_trapezoid();
        test_hysteresis();
        test_backpressure();
        test_pileup();
        test_dead_time();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
